hps_ext_host: RTL and testbench

HPS_EXT_HOST -- requirements
Module: hps_ext_host

---
 rtl/hps_ext_host.sv | 237 +++++++++++++++++++++++
 tb/tb_hps_ext_host.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hps_ext_host.sv
// hps_ext_host: host-side controller for the HPS extension bus.
// While idle it polls the target with CD_GET every POLL_INTERVAL cycles and
// forwards new messages on rx_*. Pending caller messages go out as CD_SET.
// Every transaction is a SETUP cycle, four strobes and an IDLE_GAP quiet period.
// Optional build macro: HPS_HOST_ERRCHK_EN. When it is defined, the controller
// uses dout_en to detect an unclaimed command and reports it on err_nodev.
module hps_ext_host #(
  parameter int POLL_INTERVAL = 1024,
  parameter int STROBE_GAP    = 2,
  parameter int IDLE_GAP      = 2
) (
  input  logic        clk_sys,
  input  logic        reset,
  inout  wire  [35:0] EXT_BUS,
  input  logic        tx_valid,
  input  logic [47:0] tx_data,
  output logic        tx_ready,
  output logic        rx_valid,
  output logic [47:0] rx_data,
  output logic [7:0]  rx_count,
  output logic        busy,
  output logic        err_nodev
);

  localparam int TW   = $clog2(POLL_INTERVAL + 1);
  localparam int GMAX = (STROBE_GAP > IDLE_GAP) ? STROBE_GAP : IDLE_GAP;
  localparam int CW   = $clog2(GMAX + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    WAIT   = 3'd3,
    SAMPLE = 3'd4,
    GAP    = 3'd5
  } state_t;

  state_t         state_r;
  logic           enable_r;
  logic           strobe_r;
  logic [15:0]    word_r;
  logic           tx_ready_r;
  logic           rx_valid_r;
  logic [47:0]    rx_data_r;
  logic [7:0]     rx_count_r;
  logic           busy_r;
  logic [TW-1:0]  poll_r;
  logic           poll_pend_r;
  logic           is_set_r;
  logic [1:0]     idx_r;
  logic [CW-1:0]  cnt_r;
  logic [47:0]    payload_r;
  logic [7:0]     cnt_buf_r;
  logic [31:0]    rx_buf_r;
  logic [15:0]    rsp_s;
  logic           want_set_s;
  logic           load_tx_s;
  logic           nodev_s;
  logic           poll_due_s;

  // Word driven on the bus for strobe idx of the current transaction.
  function automatic logic [15:0] word_for(input logic [1:0] idx, input logic is_set,
                                           input logic [47:0] payload);
    logic [15:0] w;
    case (idx)
      2'd0:    w = is_set ? 16'h0035 : 16'h0034;
      2'd1:    w = is_set ? payload[15:0]  : 16'h0000;
      2'd2:    w = is_set ? payload[31:16] : 16'h0000;
      2'd3:    w = is_set ? payload[47:32] : 16'h0000;
      default: w = 16'h0000;
    endcase
    return w;
  endfunction

  assign EXT_BUS[31:16] = word_r;
  assign EXT_BUS[33]    = strobe_r;
  assign EXT_BUS[34]    = enable_r;
  assign rsp_s          = EXT_BUS[15:0];
  assign poll_due_s     = poll_pend_r | (poll_r == {TW{1'b0}});

`ifdef HPS_HOST_ERRCHK_EN
  logic err_r;
  logic retry_r;
  // A CD_SET that was not claimed is resent from the held payload.
  assign want_set_s = tx_valid | retry_r;
  assign load_tx_s  = ~retry_r;
  assign nodev_s    = ~EXT_BUS[32] & (idx_r == 2'd0);
  assign err_nodev  = err_r;

  // Sticky no-device flag and pending CD_SET retry.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      err_r   <= 1'b0;
      retry_r <= 1'b0;
    end else if (state_r == SAMPLE && nodev_s) begin
      err_r   <= 1'b1;
      retry_r <= is_set_r;
    end else if (state_r == SAMPLE && idx_r == 2'd3 && is_set_r) begin
      retry_r <= 1'b0;
    end
  end
`else
  logic unused_bus_s;
  assign want_set_s   = tx_valid;
  assign load_tx_s    = 1'b1;
  assign nodev_s      = 1'b0;
  assign err_nodev    = 1'b0;
  assign unused_bus_s = ^EXT_BUS[35:32];
`endif

  // Transaction sequencer: poll timer, bus drive, response capture and pulses.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      enable_r    <= 1'b0;
      strobe_r    <= 1'b0;
      word_r      <= 16'h0000;
      tx_ready_r  <= 1'b0;
      rx_valid_r  <= 1'b0;
      rx_data_r   <= 48'h0;
      rx_count_r  <= 8'h00;
      busy_r      <= 1'b0;
      poll_r      <= TW'(POLL_INTERVAL);
      poll_pend_r <= 1'b0;
      is_set_r    <= 1'b0;
      idx_r       <= 2'd0;
      cnt_r       <= {CW{1'b0}};
      payload_r   <= 48'h0;
      cnt_buf_r   <= 8'h00;
      rx_buf_r    <= 32'h0;
    end else begin
      tx_ready_r <= 1'b0;
      rx_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (poll_r != {TW{1'b0}}) begin
            poll_r <= poll_r - TW'(1);
          end
          if (want_set_s) begin
            // CD_SET wins; a simultaneous poll expiry is remembered.
            if (poll_r == {TW{1'b0}}) begin
              poll_pend_r <= 1'b1;
            end
            if (load_tx_s) begin
              payload_r <= tx_data;
            end
            is_set_r <= 1'b1;
            idx_r    <= 2'd0;
            enable_r <= 1'b1;
            busy_r   <= 1'b1;
            state_r  <= SETUP;
          end else if (poll_due_s) begin
            poll_pend_r <= 1'b0;
            is_set_r    <= 1'b0;
            idx_r       <= 2'd0;
            enable_r    <= 1'b1;
            busy_r      <= 1'b1;
            state_r     <= SETUP;
          end
        end
        SETUP: begin
          strobe_r <= 1'b1;
          word_r   <= word_for(2'd0, is_set_r, payload_r);
          state_r  <= STROBE;
        end
        STROBE: begin
          strobe_r <= 1'b0;
          state_r  <= SAMPLE;
        end
        SAMPLE: begin
          case (idx_r)
            2'd0:    cnt_buf_r        <= rsp_s[7:0];
            2'd1:    rx_buf_r[15:0]   <= rsp_s;
            2'd2:    rx_buf_r[31:16]  <= rsp_s;
            default: rx_buf_r         <= rx_buf_r;
          endcase
          if (nodev_s || idx_r == 2'd3) begin
            // Last word (or unclaimed command): close the transaction.
            if (!nodev_s && !is_set_r && cnt_buf_r != rx_count_r) begin
              rx_data_r  <= {rsp_s, rx_buf_r};
              rx_count_r <= cnt_buf_r;
              rx_valid_r <= 1'b1;
            end
            enable_r <= 1'b0;
            word_r   <= 16'h0000;
            cnt_r    <= CW'(IDLE_GAP - 1);
            state_r  <= GAP;
          end else begin
            idx_r <= idx_r + 2'd1;
            if (STROBE_GAP == 2) begin
              strobe_r   <= 1'b1;
              word_r     <= word_for(idx_r + 2'd1, is_set_r, payload_r);
              tx_ready_r <= is_set_r & (idx_r == 2'd2);
              state_r    <= STROBE;
            end else begin
              cnt_r   <= CW'(STROBE_GAP - 3);
              state_r <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt_r == {CW{1'b0}}) begin
            strobe_r   <= 1'b1;
            word_r     <= word_for(idx_r, is_set_r, payload_r);
            tx_ready_r <= is_set_r & (idx_r == 2'd3);
            state_r    <= STROBE;
          end else begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
        GAP: begin
          if (cnt_r == {CW{1'b0}}) begin
            busy_r  <= 1'b0;
            poll_r  <= TW'(POLL_INTERVAL);
            state_r <= IDLE;
          end else begin
            cnt_r <= cnt_r - CW'(1);
          end
        end
        default: begin
          enable_r <= 1'b0;
          strobe_r <= 1'b0;
          word_r   <= 16'h0000;
          busy_r   <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

  assign tx_ready = tx_ready_r;
  assign rx_valid = rx_valid_r;
  assign rx_data  = rx_data_r;
  assign rx_count = rx_count_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_hps_ext_host.sv
// tb_hps_ext_host: scoreboard bench for hps_ext_host with a 1-cycle-latency
// target model on EXT_BUS.
module tb_hps_ext_host;

  localparam int P  = 16;
  localparam int SG = 2;
  localparam int IG = 2;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  wire  [35:0] ext_bus;
  logic        tx_valid = 1'b0;
  logic [47:0] tx_data  = 48'h0;
  logic        tx_ready, rx_valid, busy, err_nodev;
  logic [47:0] rx_data;
  logic [7:0]  rx_count;

  logic [15:0] tgt_resp [4];
  logic [15:0] tgt_word;
  logic [1:0]  tgt_k;
  logic        tgt_dout_en = 1'b1;

  logic [15:0] exp_words [$];
  logic [55:0] exp_rx [$];
  int n_checks = 0;
  int n_fail   = 0;
  int tx_seen  = 0;
  int rx_seen  = 0;
  int cyc      = 0;
  int last_strobe_cyc = 0;
  int strobe_idx = 0;

  wire        enable_w = ext_bus[34];
  wire        strobe_w = ext_bus[33];
  wire [15:0] word_w   = ext_bus[31:16];

  assign ext_bus[15:0] = tgt_word;
  assign ext_bus[32]   = tgt_dout_en;

  hps_ext_host #(.POLL_INTERVAL(P), .STROBE_GAP(SG), .IDLE_GAP(IG)) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .EXT_BUS  (ext_bus),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_count (rx_count),
    .busy     (busy),
    .err_nodev(err_nodev)
  );

  always #5 clk_sys = ~clk_sys;

  // Cycle counter used for strobe spacing.
  always @(posedge clk_sys) cyc <= cyc + 1;

  // Target: answers each strobe with the next table entry one cycle later.
  always @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      tgt_k    <= 2'd0;
      tgt_word <= 16'h0000;
    end else if (!enable_w) begin
      tgt_k <= 2'd0;
    end else if (strobe_w) begin
      tgt_word <= tgt_resp[tgt_k];
      tgt_k    <= tgt_k + 2'd1;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: compares every strobe word, tx_ready and rx_valid with the queues.
  initial begin
    forever begin
      @(negedge clk_sys);
      if (!reset) begin
        if (!enable_w) strobe_idx = 0;
        if (strobe_w) begin
          chk("strobe_expected", exp_words.size() > 0, 1);
          if (exp_words.size() > 0) chk("strobe_word", word_w, exp_words.pop_front());
          if (strobe_idx > 0) chk("strobe_spacing", cyc - last_strobe_cyc, SG);
          last_strobe_cyc = cyc;
          strobe_idx++;
        end
        if (tx_ready) begin
          tx_seen++;
          chk("tx_ready_on_word3", strobe_idx, 4);
        end
        if (rx_valid) begin
          logic [55:0] e;
          rx_seen++;
          chk("rx_valid_expected", exp_rx.size() > 0, 1);
          if (exp_rx.size() > 0) begin
            e = exp_rx.pop_front();
            chk("rx_data", rx_data, e[55:8]);
            chk("rx_count", rx_count, e[7:0]);
          end
        end
      end
    end
  end

  task automatic wait_enable_rise(output int n);
    logic got = 1'b0;
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk_sys); #1;
      n++;
      if (enable_w) begin got = 1'b1; break; end
    end
    chk("wait_enable_rise", got, 1);
  endtask

  task automatic wait_enable_fall();
    logic got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk_sys); #1;
      if (!enable_w) begin got = 1'b1; break; end
    end
    chk("wait_enable_fall", got, 1);
  endtask

  task automatic wait_idle();
    logic got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk_sys); #1;
      if (!busy) begin got = 1'b1; break; end
    end
    chk("wait_idle", got, 1);
  endtask

  task automatic wait_tx_ready();
    logic got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk_sys); #1;
      if (tx_ready) begin got = 1'b1; break; end
    end
    chk("wait_tx_ready", got, 1);
  endtask

  task automatic push_get();
    exp_words.push_back(16'h0034);
    repeat (3) exp_words.push_back(16'h0000);
  endtask

  task automatic push_set(input logic [47:0] d);
    exp_words.push_back(16'h0035);
    exp_words.push_back(d[15:0]);
    exp_words.push_back(d[31:16]);
    exp_words.push_back(d[47:32]);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    tgt_resp = '{16'h0001, 16'h0034, 16'h0000, 16'h0000};

    // Reset state.
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    chk("rst_enable", enable_w, 1'b0);
    chk("rst_strobe", strobe_w, 1'b0);
    chk("rst_word", word_w, 16'h0000);
    chk("rst_tx_ready", tx_ready, 1'b0);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_rx_data", rx_data, 48'h0);
    chk("rst_rx_count", rx_count, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err_nodev", err_nodev, 1'b0);

    // First poll lands POLL_INTERVAL+1 cycles after release; count 0x01 is new.
    reset = 1'b0;
    push_get();
    exp_rx.push_back({48'h0000_0000_0034, 8'h01});
    wait_enable_rise(n);
    chk("first_poll_cycle", n, P + 1);
    chk("busy_with_enable", busy, 1'b1);
    wait_idle();
    chk("rx_count_after_poll1", rx_seen, 1);

    // Same count again: no new message.
    push_get();
    wait_enable_rise(n);
    wait_idle();
    chk("rx_none_same_count", rx_seen, 1);
    chk("rx_count_held", rx_count, 8'h01);
    chk("rx_data_held", rx_data, 48'h0000_0000_0034);

    // CD_SET with a two-cycle quiet period afterwards.
    tgt_resp = '{16'h0005, 16'h1111, 16'h1111, 16'h1111};
    @(negedge clk_sys);
    tx_data  = 48'h1234_5678_0002;
    tx_valid = 1'b1;
    push_set(48'h1234_5678_0002);
    wait_tx_ready();
    tx_valid = 1'b0;
    wait_enable_fall();
    n = 1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_sys); #1;
      if (busy && !enable_w) n++;
      else break;
    end
    chk("idle_gap_len", n, IG);
    chk("tx_ready_count_set1", tx_seen, 1);
    chk("rx_none_after_set", rx_seen, 1);

    // tx_valid rises exactly when the poll timer expires: CD_SET, then CD_GET.
    tgt_resp = '{16'h0002, 16'hEEFF, 16'hCCDD, 16'hAABB};
    repeat (P) @(posedge clk_sys);
    @(negedge clk_sys);
    tx_data  = 48'hCAFE_F00D_0007;
    tx_valid = 1'b1;
    push_set(48'hCAFE_F00D_0007);
    push_get();
    exp_rx.push_back({48'hAABB_CCDD_EEFF, 8'h02});
    wait_tx_ready();
    tx_valid = 1'b0;
    wait_enable_fall();
    // Low run = IDLE_GAP quiet cycles plus the single IDLE decision cycle.
    n = 1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_sys); #1;
      if (!enable_w) n++;
      else break;
    end
    chk("pending_poll_back_to_back", n, IG + 1);
    wait_idle();
    chk("tx_ready_count_set2", tx_seen, 2);
    chk("rx_count_after_pending_poll", rx_seen, 2);

    // Count wrap 0xFF -> 0x00 is a new message.
    tgt_resp = '{16'h00FF, 16'h1111, 16'h2222, 16'h3333};
    push_get();
    exp_rx.push_back({48'h3333_2222_1111, 8'hFF});
    wait_enable_rise(n);
    wait_idle();
    tgt_resp = '{16'h0000, 16'h4444, 16'h5555, 16'h6666};
    push_get();
    exp_rx.push_back({48'h6666_5555_4444, 8'h00});
    wait_enable_rise(n);
    wait_idle();
    chk("rx_count_after_wrap", rx_seen, 4);
    chk("rx_count_wrapped", rx_count, 8'h00);

    // Reset between word1 and word2 aborts silently.
    tgt_resp = '{16'h0033, 16'h7777, 16'h8888, 16'h9999};
    push_get();
    wait_enable_rise(n);
    n = 0;
    for (int i = 0; i < 20 && n < 2; i++) begin
      @(posedge clk_sys); #1;
      if (strobe_w) n++;
    end
    chk("abort_saw_word1", n, 2);
    @(posedge clk_sys); #1;
    chk("abort_enable_before", enable_w, 1'b1);
    reset = 1'b1;
    #1;
    chk("abort_enable_now", enable_w, 1'b0);
    chk("abort_strobe_now", strobe_w, 1'b0);
    exp_words.delete();
    repeat (2) @(posedge clk_sys);
    #1;
    chk("abort_rx_data", rx_data, 48'h0);
    chk("abort_rx_count", rx_count, 8'h00);
    chk("abort_busy", busy, 1'b0);
    chk("abort_tx_seen", tx_seen, 2);
    chk("abort_rx_seen", rx_seen, 4);
    @(negedge clk_sys);
    reset = 1'b0;
    push_get();
    exp_rx.push_back({48'h9999_8888_7777, 8'h33});
    wait_enable_rise(n);
    chk("poll_after_reset_cycle", n, P + 1);
    wait_idle();
    chk("rx_count_after_reset_poll", rx_seen, 5);

`ifdef HPS_HOST_ERRCHK_EN
    // Unclaimed command: one strobe only, sticky err_nodev.
    tgt_dout_en = 1'b0;
    exp_words.push_back(16'h0034);
    wait_enable_rise(n);
    wait_idle();
    chk("nodev_err_set", err_nodev, 1'b1);
    tgt_dout_en = 1'b1;
    push_get();
    wait_enable_rise(n);
    wait_idle();
    chk("nodev_err_sticky", err_nodev, 1'b1);
`else
    chk("err_nodev_zero", err_nodev, 1'b0);
`endif

    chk("exp_words_drained", exp_words.size(), 0);
    chk("exp_rx_drained", exp_rx.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
